decode_cycle: RTL and testbench

Decode stage of the five-stage RV32I pipeline, directly downstream of instruction fetch. It takes the fetched instruction, PC and PC+4 from the IF/ID register, decodes control, reads the 32×32 register file, and sign-extends the immediate. It registers everything into the ID/EX pipeline register for the execute stage. It also owns the architectural register file, which the writeback stage writes through the W-side ports.

---
 rtl/riscv_pkg.sv | 73 +++++++
 rtl/decode_cycle_if.sv | 47 ++++
 rtl/decode_cycle_reg_file.sv | 36 +++
 rtl/decode_cycle.sv | 168 ++++++++++++++++
 tb/tb_decode_cycle.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/ResultSrc/ImmSrc encodings and the
// ID/EX pipeline register layout used by the decode stage.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluControl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultSrc_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immSrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluOp_e;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    logic       immEn;
    resultSrc_e resultSrc;
    immSrc_e    immSrc;
    aluOp_e     aluOp;
  } ctrl_t;

  typedef struct packed {
    logic              regWrite;
    logic              memWrite;
    logic              jump;
    logic              branch;
    logic              aluSrc;
    logic [1:0]        resultSrc;
    logic [2:0]        aluControl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   immExt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pcPlus4;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } idex_t;

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard-unit indices and ID/EX outputs.
// master drives the stage inputs (fetch/writeback side), slave is the decode stage.
interface decode_cycle_if;
  import riscv_pkg::*;

  logic [XLEN-1:0]   InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              FlushE;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;

  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;

  logic              RegWriteE;
  logic              MemWriteE;
  logic              JumpE;
  logic              BranchE;
  logic              ALUSrcE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;

  modport master (
    output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    input  Rs1D, Rs2D,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    output Rs1D, Rs2D,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
  );

endinterface

// File: rtl/decode_cycle_reg_file.sv
// Architectural 32x32 register file: two async read ports, one write port, x0 hardwired to 0.
// Optional RF_BYPASS_EN forwards the in-flight write data to a matching read port.
module reg_file
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] a1,
  input  logic [REG_AW-1:0] a2,
  input  logic [REG_AW-1:0] a3,
  input  logic              we3,
  input  logic [XLEN-1:0]   wd3,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we3 && (a3 != '0)) begin
      regs[a3] <= wd3;
    end
  end

`ifdef RF_BYPASS_EN
  // a nonzero read address already implies a nonzero write address on a match
  assign rd1 = (a1 == '0) ? '0 : ((we3 && (a1 == a3)) ? wd3 : regs[a1]);
  assign rd2 = (a2 == '0) ? '0 : ((we3 && (a2 == a3)) ? wd3 : regs[a2]);
`else
  assign rd1 = (a1 == '0) ? '0 : regs[a1];
  assign rd2 = (a2 == '0) ? '0 : regs[a2];
`endif

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension, register read and ID/EX register.
// Build option RF_BYPASS_EN enables write-through forwarding inside reg_file.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_cycle_if.slave  bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  ctrl_t           ctrlD;
  logic [2:0]      aluControlD;
  logic signed [XLEN-1:0] immExtD;
  logic [XLEN-1:0] rd1D;
  logic [XLEN-1:0] rd2D;
  idex_t           idExD;
  idex_t           idEx_p1;

  assign opcode   = bus.InstrD[6:0];
  assign funct3   = bus.InstrD[14:12];
  assign funct7b5 = bus.InstrD[30];

  assign bus.Rs1D = bus.InstrD[19:15];
  assign bus.Rs2D = bus.InstrD[24:20];

  always_comb begin
    ctrlD.regWrite  = 1'b0;
    ctrlD.memWrite  = 1'b0;
    ctrlD.jump      = 1'b0;
    ctrlD.branch    = 1'b0;
    ctrlD.aluSrc    = 1'b0;
    ctrlD.immEn     = 1'b0;
    ctrlD.resultSrc = RES_ALU;
    ctrlD.immSrc    = IMM_I;
    ctrlD.aluOp     = ALUOP_ADD;
    case (opcode)
      OP_LW: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.aluSrc    = 1'b1;
        ctrlD.immEn     = 1'b1;
        ctrlD.resultSrc = RES_MEM;
      end
      OP_SW: begin
        ctrlD.memWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        ctrlD.immEn    = 1'b1;
        ctrlD.immSrc   = IMM_S;
      end
      OP_RTYPE: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluOp    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        ctrlD.branch = 1'b1;
        ctrlD.immEn  = 1'b1;
        ctrlD.immSrc = IMM_B;
        ctrlD.aluOp  = ALUOP_SUB;
      end
      OP_IALU: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        ctrlD.immEn    = 1'b1;
        ctrlD.aluOp    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.immEn     = 1'b1;
        ctrlD.immSrc    = IMM_J;
        ctrlD.resultSrc = RES_PC4;
      end
      default: ;
    endcase
  end

  always_comb begin
    aluControlD = ALU_ADD;
    case (ctrlD.aluOp)
      ALUOP_SUB: aluControlD = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has no funct7, so only an R-type with funct7[5] set is a subtract
          3'b000:  aluControlD = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControlD = ALU_SLT;
          3'b110:  aluControlD = ALU_OR;
          3'b111:  aluControlD = ALU_AND;
          default: aluControlD = ALU_ADD;
        endcase
      end
      default: aluControlD = ALU_ADD;
    endcase
  end

  function automatic logic signed [XLEN-1:0] extendImm(input logic [XLEN-1:0] instr,
                                                       input immSrc_e src);
    logic s;
    s = instr[31];
    case (src)
      IMM_S:   extendImm = {{20{s}}, instr[31:25], instr[11:7]};
      IMM_B:   extendImm = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   extendImm = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: extendImm = {{20{s}}, instr[31:20]};
    endcase
  endfunction

  assign immExtD = ctrlD.immEn ? extendImm(bus.InstrD, ctrlD.immSrc) : '0;

  reg_file u_regFile (
    .clk (clk),
    .rst (rst),
    .a1  (bus.Rs1D),
    .a2  (bus.Rs2D),
    .a3  (bus.RdW),
    .we3 (bus.RegWriteW),
    .wd3 (bus.ResultW),
    .rd1 (rd1D),
    .rd2 (rd2D)
  );

  always_comb begin
    idExD.regWrite   = ctrlD.regWrite;
    idExD.memWrite   = ctrlD.memWrite;
    idExD.jump       = ctrlD.jump;
    idExD.branch     = ctrlD.branch;
    idExD.aluSrc     = ctrlD.aluSrc;
    idExD.resultSrc  = ctrlD.resultSrc;
    idExD.aluControl = aluControlD;
    idExD.rd1        = rd1D;
    idExD.rd2        = rd2D;
    idExD.immExt     = immExtD;
    idExD.pc         = bus.PCD;
    idExD.pcPlus4    = bus.PCPlus4D;
    idExD.rd         = bus.InstrD[11:7];
    idExD.rs1        = bus.Rs1D;
    idExD.rs2        = bus.Rs2D;
  end

  // ---- ID/EX boundary: flush outranks the decoded contents ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idEx_p1 <= '0;
    end else if (bus.FlushE) begin
      idEx_p1 <= '0;
    end else begin
      idEx_p1 <= idExD;
    end
  end

  assign bus.RegWriteE   = idEx_p1.regWrite;
  assign bus.MemWriteE   = idEx_p1.memWrite;
  assign bus.JumpE       = idEx_p1.jump;
  assign bus.BranchE     = idEx_p1.branch;
  assign bus.ALUSrcE     = idEx_p1.aluSrc;
  assign bus.ResultSrcE  = idEx_p1.resultSrc;
  assign bus.ALUControlE = idEx_p1.aluControl;
  assign bus.RD1E        = idEx_p1.rd1;
  assign bus.RD2E        = idEx_p1.rd2;
  assign bus.ImmExtE     = idEx_p1.immExt;
  assign bus.PCE         = idEx_p1.pc;
  assign bus.PCPlus4E    = idEx_p1.pcPlus4;
  assign bus.RdE         = idEx_p1.rd;
  assign bus.Rs1E        = idEx_p1.rs1;
  assign bus.Rs2E        = idEx_p1.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: expected ID/EX contents are queued as each
// instruction is driven and compared one edge later.
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrc;
    logic [1:0]  resultSrc;
    logic [2:0]  aluControl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immExt;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t        expQ[$];
  exp_t        e;
  exp_t        zeroExp;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc = 32'h0000_0100;
  logic [31:0] bypassX5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic compareAll(input string tag, input exp_t x);
    check({tag, ".RegWriteE"},   {31'b0, bus.RegWriteE},  {31'b0, x.regWrite});
    check({tag, ".MemWriteE"},   {31'b0, bus.MemWriteE},  {31'b0, x.memWrite});
    check({tag, ".JumpE"},       {31'b0, bus.JumpE},      {31'b0, x.jump});
    check({tag, ".BranchE"},     {31'b0, bus.BranchE},    {31'b0, x.branch});
    check({tag, ".ALUSrcE"},     {31'b0, bus.ALUSrcE},    {31'b0, x.aluSrc});
    check({tag, ".ResultSrcE"},  {30'b0, bus.ResultSrcE}, {30'b0, x.resultSrc});
    check({tag, ".ALUControlE"}, {29'b0, bus.ALUControlE}, {29'b0, x.aluControl});
    check({tag, ".RD1E"},        bus.RD1E,     x.rd1);
    check({tag, ".RD2E"},        bus.RD2E,     x.rd2);
    check({tag, ".ImmExtE"},     bus.ImmExtE,  x.immExt);
    check({tag, ".PCE"},         bus.PCE,      x.pc);
    check({tag, ".PCPlus4E"},    bus.PCPlus4E, x.pcPlus4);
    check({tag, ".RdE"},         {27'b0, bus.RdE},  {27'b0, x.rd});
    check({tag, ".Rs1E"},        {27'b0, bus.Rs1E}, {27'b0, x.rs1});
    check({tag, ".Rs2E"},        {27'b0, bus.Rs2E}, {27'b0, x.rs2});
  endtask

  // Caller fills e with control/data/index expectations; PC fields are added here.
  task automatic step(input string tag, input logic [31:0] instr, input logic flush,
                      input logic we, input logic [4:0] rdw, input logic [31:0] res);
    exp_t got;
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.FlushE    = flush;
    bus.RegWriteW = we;
    bus.RdW       = rdw;
    bus.ResultW   = res;
    if (!flush) begin
      e.pc      = pc;
      e.pcPlus4 = pc + 32'd4;
    end
    expQ.push_back(e);
    pc = pc + 32'd4;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      got = expQ.pop_front();
      compareAll(tag, got);
    end
    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zeroExp = '0;
`ifdef RF_BYPASS_EN
    bypassX5 = 32'h0000_0011;
`else
    bypassX5 = 32'hDEAD_BEEF;
`endif
    bus.InstrD    = 32'h0050_0093;
    bus.PCD       = 32'h0000_0100;
    bus.PCPlus4D  = 32'h0000_0104;
    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.RdW       = 5'd0;
    bus.ResultW   = 32'h0;

    // asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    compareAll("rst_async", zeroExp);
    check("rst.Rs1D", {27'b0, bus.Rs1D}, 32'd0);
    check("rst.Rs2D", {27'b0, bus.Rs2D}, 32'd5);
    @(posedge clk);
    #1;
    compareAll("rst_held", zeroExp);
    rst = 1'b0;

    // addi x1,x0,5 captured on the first edge after release
    e = '0; e.regWrite = 1; e.aluSrc = 1; e.immExt = 32'd5; e.rd = 5'd1; e.rs2 = 5'd5;
    step("addi_x1", 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0);

    // nop while writing x5
    e = '0; e.regWrite = 1; e.aluSrc = 1;
    step("nop_wr_x5", 32'h0000_0013, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);

    // addi x6,x5,0 reads back x5; x0 write attempted in parallel
    e = '0; e.regWrite = 1; e.aluSrc = 1; e.rd1 = 32'hDEAD_BEEF; e.rd = 5'd6; e.rs1 = 5'd5;
    step("rd_x5", 32'h0002_8313, 1'b0, 1'b1, 5'd0, 32'h0000_1234);

    // add x0,x0,x0: x0 still reads 0
    e = '0; e.regWrite = 1;
    step("rd_x0", 32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'h0);

    // add x7,x5,x5 during a same-cycle write of x5
    e = '0; e.regWrite = 1; e.rd1 = bypassX5; e.rd2 = bypassX5;
    e.rd = 5'd7; e.rs1 = 5'd5; e.rs2 = 5'd5;
    step("same_cycle", 32'h0052_83B3, 1'b0, 1'b1, 5'd5, 32'h0000_0011);

    e = '0; e.regWrite = 1; e.aluSrc = 1; e.rd1 = 32'h0000_0011; e.rd = 5'd6; e.rs1 = 5'd5;
    step("x5_committed", 32'h0002_8313, 1'b0, 1'b0, 5'd0, 32'h0);

    // beq x0,x0,-4
    e = '0; e.branch = 1; e.aluControl = 3'b001; e.immExt = 32'hFFFF_FFFC; e.rd = 5'd29;
    step("beq_neg4", 32'hFE00_0EE3, 1'b0, 1'b0, 5'd0, 32'h0);

    // jal x1,+8
    e = '0; e.regWrite = 1; e.jump = 1; e.resultSrc = 2'b10; e.immExt = 32'd8;
    e.rd = 5'd1; e.rs2 = 5'd8;
    step("jal_p8", 32'h0080_00EF, 1'b0, 1'b0, 5'd0, 32'h0);

    // flush a sw while x8 is written independently
    e = '0;
    step("flush_sw", 32'h0011_2223, 1'b1, 1'b1, 5'd8, 32'h0000_0055);

    e = '0; e.memWrite = 1; e.aluSrc = 1; e.immExt = 32'd4; e.rd = 5'd4; e.rs1 = 5'd2; e.rs2 = 5'd1;
    step("sw_after", 32'h0011_2223, 1'b0, 1'b0, 5'd0, 32'h0);

    e = '0; e.regWrite = 1; e.aluSrc = 1; e.rd1 = 32'h0000_0055; e.rd = 5'd6; e.rs1 = 5'd8;
    step("flush_wr_x8", 32'h0004_0313, 1'b0, 1'b0, 5'd0, 32'h0);

    // ALU decode of R-type funct3/funct7
    e = '0; e.regWrite = 1; e.aluControl = 3'b001; e.rd = 5'd10; e.rs1 = 5'd10; e.rs2 = 5'd11;
    step("sub", 32'h40B5_0533, 1'b0, 1'b0, 5'd0, 32'h0);
    e = '0; e.regWrite = 1; e.aluControl = 3'b101; e.rd = 5'd5; e.rs1 = 5'd6; e.rs2 = 5'd7;
    step("slt", 32'h0073_22B3, 1'b0, 1'b0, 5'd0, 32'h0);
    e = '0; e.regWrite = 1; e.aluControl = 3'b010; e.rd = 5'd5; e.rs1 = 5'd6; e.rs2 = 5'd7;
    step("and", 32'h0073_72B3, 1'b0, 1'b0, 5'd0, 32'h0);
    e = '0; e.regWrite = 1; e.aluControl = 3'b011; e.rd = 5'd5; e.rs1 = 5'd6; e.rs2 = 5'd7;
    step("or", 32'h0073_62B3, 1'b0, 1'b0, 5'd0, 32'h0);

    // illegal opcode decodes as a bubble
    e = '0;
    step("illegal", 32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'h0);

    // reset arriving during a pending write of x9
    bus.InstrD    = 32'h0000_0013;
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd9;
    bus.ResultW   = 32'h0000_0099;
    #2 rst = 1'b1;
    #1;
    compareAll("rst_mid", zeroExp);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.RegWriteW = 1'b0;

    e = '0; e.regWrite = 1; e.aluSrc = 1; e.rd = 5'd6; e.rs1 = 5'd9;
    step("x9_lost", 32'h0004_8313, 1'b0, 1'b0, 5'd0, 32'h0);
    e = '0; e.regWrite = 1; e.aluSrc = 1; e.rd = 5'd6; e.rs1 = 5'd5;
    step("x5_cleared", 32'h0002_8313, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
